// File: rtl/mips_stage_fwd_if.sv
// mips_stage_fwd_if
//   Signal bundle for the operand-forwarding / load-use hazard unit.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   advance      : pipeline moves this cycle (0 = every register holds)
//   decRs/decRt, decRsVal/decRtVal : decode sources and register-file data
//   exWrite/exLoad/exRd/exResult   : the instruction currently in EX
//   memData      : load data for the instruction currently in MEM
//   regPort1/2   : registered forwarded operands (rs, rt) for EX
//   stall        : combinational load-use hazard
//   stallCount   : saturating stall-cycle counter (0 when stats disabled)
// Handshake: there is no valid/ready pair; every input is sampled on each
// rising edge where advance=1, and outputs update only on those edges.
interface mips_stage_fwd_if;
  logic        clock;
  logic        reset;
  logic        advance;
  logic [4:0]  decRs;
  logic [4:0]  decRt;
  logic [31:0] decRsVal;
  logic [31:0] decRtVal;
  logic        exWrite;
  logic        exLoad;
  logic [4:0]  exRd;
  logic [31:0] exResult;
  logic [31:0] memData;
  logic [31:0] regPort1;
  logic [31:0] regPort2;
  logic        stall;
  logic [15:0] stallCount;

  modport master (
    output clock, reset, advance, decRs, decRt, decRsVal, decRtVal,
           exWrite, exLoad, exRd, exResult, memData,
    input  regPort1, regPort2, stall, stallCount
  );

  modport slave (
    input  clock, reset, advance, decRs, decRt, decRsVal, decRtVal,
           exWrite, exLoad, exRd, exResult, memData,
    output regPort1, regPort2, stall, stallCount
  );
endinterface

// File: rtl/mips_stage_fwd.sv
// mips_stage_fwd
//   Producer side of the EX-stage forward channel. Tracks EX, MEM (slot M)
//   and WB (slot W) destinations/results, picks each decode operand from the
//   youngest in-flight producer or the register file, and registers the
//   result into regPort1/regPort2 for the execute stage one cycle later.
//   Raises a combinational stall on load-use hazards and inserts a bubble.
// Ports: single interface port 'ctrl' (mips_stage_fwd_if.slave); see the
//   interface file for the per-signal summary.
// Optional feature: define MIPS_STAGE_FWD_STATS_EN to build the saturating
//   stall-cycle counter; otherwise stallCount is tied to zero.
// Debug: slot state is visible through dbg_m_o/dbg_w_o packed structs
//   (hierarchical access) for checker binding.
module mips_stage_fwd (
  mips_stage_fwd_if.slave ctrl
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        load;
    logic [31:0] value;
  } m_slot_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] value;
  } w_slot_t;

  m_slot_t     m_q, m_d;
  w_slot_t     w_q, w_d;
  logic [31:0] port1_q, port1_d;
  logic [31:0] port2_q, port2_d;
  logic        stall_w;

  m_slot_t     dbg_m_o;
  w_slot_t     dbg_w_o;
  assign dbg_m_o = m_q;
  assign dbg_w_o = w_q;

  // Operand select, youngest producer first. r0 never matches any slot so it
  // always falls through to the register-file value.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] rf_val,
    input logic        ex_write,
    input logic        ex_load,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_result,
    input m_slot_t     m,
    input w_slot_t     w,
    input logic [31:0] mem_data
  );
    logic [31:0] r;
    r = rf_val;
    if (src != 5'd0) begin
      if (ex_write && !ex_load && (ex_rd == src))
        r = ex_result;
      else if (m.valid && (m.rd == src))
        r = m.load ? mem_data : m.value;
      else if (w.valid && (w.rd == src))
        r = w.value;
    end
    return r;
  endfunction

  // A load in EX has no data yet; any dependent decode must wait one cycle
  // and pick the data up from MEM through the load branch of fwd_sel.
  assign stall_w = ctrl.exWrite && ctrl.exLoad && (ctrl.exRd != 5'd0) &&
                   ((ctrl.exRd == ctrl.decRs) || (ctrl.exRd == ctrl.decRt));

  always_comb begin
    m_d     = m_q;
    w_d     = w_q;
    port1_d = port1_q;
    port2_d = port2_q;
    if (ctrl.advance) begin
      w_d.valid = m_q.valid;
      w_d.rd    = m_q.rd;
      w_d.value = m_q.load ? ctrl.memData : m_q.value;
      m_d.valid = ctrl.exWrite;
      m_d.rd    = ctrl.exRd;
      m_d.load  = ctrl.exLoad;
      m_d.value = ctrl.exResult;
      if (stall_w) begin
        port1_d = 32'h0;
        port2_d = 32'h0;
      end else begin
        port1_d = fwd_sel(ctrl.decRs, ctrl.decRsVal, ctrl.exWrite, ctrl.exLoad,
                          ctrl.exRd, ctrl.exResult, m_q, w_q, ctrl.memData);
        port2_d = fwd_sel(ctrl.decRt, ctrl.decRtVal, ctrl.exWrite, ctrl.exLoad,
                          ctrl.exRd, ctrl.exResult, m_q, w_q, ctrl.memData);
      end
    end
  end

  always_ff @(posedge ctrl.clock or negedge ctrl.reset) begin
    if (!ctrl.reset) begin
      m_q     <= '0;
      w_q     <= '0;
      port1_q <= 32'h0;
      port2_q <= 32'h0;
    end else begin
      m_q     <= m_d;
      w_q     <= w_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
    end
  end

  assign ctrl.regPort1 = port1_q;
  assign ctrl.regPort2 = port2_q;
  assign ctrl.stall    = stall_w;

`ifdef MIPS_STAGE_FWD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.advance && stall_w && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge ctrl.clock or negedge ctrl.reset) begin
    if (!ctrl.reset) stall_cnt_q <= 16'h0;
    else             stall_cnt_q <= stall_cnt_d;
  end

  assign ctrl.stallCount = stall_cnt_q;
`else
  assign ctrl.stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_stage_fwd.sv
module tb_mips_stage_fwd;

  mips_stage_fwd_if bus ();
  mips_stage_fwd dut (.ctrl(bus));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  int          due_q[$];

`ifdef MIPS_STAGE_FWD_STATS_EN
  localparam logic [15:0] CNT_AFTER_LOAD = 16'd1;
`else
  localparam logic [15:0] CNT_AFTER_LOAD = 16'd0;
`endif

  // ---------------- clock / reset ----------------
  initial bus.clock = 1'b0;
  always #5 bus.clock = ~bus.clock;
  always @(posedge bus.clock) cyc <= cyc + 1;

  // ---------------- check helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One call = one cycle. Inputs change #1 after the falling edge; the
  // expected registered outputs for the following rising edge are queued.
  task automatic drive(input string name, input logic adv,
                       input logic [4:0] rs, input logic [31:0] rsv,
                       input logic [4:0] rt, input logic [31:0] rtv,
                       input logic w, input logic ld, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] md,
                       input logic exp_stall,
                       input logic [31:0] e1, input logic [31:0] e2);
    @(negedge bus.clock);
    #1;
    bus.advance  = adv;
    bus.decRs    = rs;
    bus.decRsVal = rsv;
    bus.decRt    = rt;
    bus.decRtVal = rtv;
    bus.exWrite  = w;
    bus.exLoad   = ld;
    bus.exRd     = rd;
    bus.exResult = res;
    bus.memData  = md;
    #1;
    check32({name, ".stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    exp1_q.push_back(e1);
    exp2_q.push_back(e2);
    due_q.push_back(cyc + 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge bus.clock) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [31:0] e1, e2;
      int d;
      d  = due_q.pop_front();
      e1 = exp1_q.pop_front();
      e2 = exp2_q.pop_front();
      check32($sformatf("regPort1@%0d", d), bus.regPort1, e1);
      check32($sformatf("regPort2@%0d", d), bus.regPort2, e2);
    end
  end

  task automatic drain();
    int guard = 0;
    while (due_q.size() > 0 && guard < 20) begin
      @(negedge bus.clock);
      guard++;
    end
    #1;
    if (due_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d entries pending, expected 0", due_q.size());
      due_q.delete(); exp1_q.delete(); exp2_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.reset = 1'b0; bus.advance = 1'b1;
    bus.decRs = 0; bus.decRt = 0; bus.decRsVal = 0; bus.decRtVal = 0;
    bus.exWrite = 0; bus.exLoad = 0; bus.exRd = 0; bus.exResult = 0; bus.memData = 0;
    repeat (3) @(posedge bus.clock);
    #2;
    check32("rst.regPort1", bus.regPort1, 32'h0);
    check32("rst.regPort2", bus.regPort2, 32'h0);
    check32("rst.stallCount", {16'd0, bus.stallCount}, 32'h0);
    @(negedge bus.clock);
    bus.reset = 1'b1;

    //     name      adv rs   rsv           rt   rtv           w  ld rd   res            md             stall e1            e2
    drive("rf",      1, 5'd5, 32'h11,       5'd0, 32'h0,       0, 0, 5'd0, 32'h0,        32'h0,         0, 32'h11,       32'h0);
    drive("exfwd",   1, 5'd3, 32'h0,        5'd0, 32'h0,       1, 0, 5'd3, 32'hA5A50001, 32'h0,         0, 32'hA5A50001, 32'h0);
    drive("pri1",    1, 5'd0, 32'h0,        5'd0, 32'h0,       1, 0, 5'd7, 32'h1,        32'h0,         0, 32'h0,        32'h0);
    drive("pri2",    1, 5'd0, 32'h0,        5'd0, 32'h0,       1, 0, 5'd7, 32'h2,        32'h0,         0, 32'h0,        32'h0);
    // EX=3, M=2, W=1 all hold r7: youngest wins; r3 has aged out -> RF value.
    drive("pri3",    1, 5'd3, 32'h55,       5'd7, 32'h99,      1, 0, 5'd7, 32'h3,        32'h0,         0, 32'h55,       32'h3);
    drive("dist2",   1, 5'd7, 32'h0,        5'd7, 32'h0,       0, 0, 5'd0, 32'h0,        32'h0,         0, 32'h3,        32'h3);
    drive("dist3",   1, 5'd7, 32'h0,        5'd0, 32'h0,       0, 0, 5'd0, 32'h0,        32'h0,         0, 32'h3,        32'h0);
    drive("lduse",   1, 5'd0, 32'h0,        5'd9, 32'h77,      1, 1, 5'd9, 32'h123,      32'h0,         1, 32'h0,        32'h0);
    drive("ldmem",   1, 5'd0, 32'h0,        5'd9, 32'h77,      0, 0, 5'd0, 32'h0,        32'hDEADBEEF,  0, 32'h0,        32'hDEADBEEF);
    drive("ldwb",    1, 5'd0, 32'h0,        5'd9, 32'h0,       0, 0, 5'd0, 32'h0,        32'h0,         0, 32'h0,        32'hDEADBEEF);
    drain();
    check32("cnt.load", {16'd0, bus.stallCount}, {16'd0, CNT_AFTER_LOAD});

    drive("r0alu",   1, 5'd0, 32'h0,        5'd0, 32'h0,       1, 0, 5'd0, 32'hFFFFFFFF, 32'h0,         0, 32'h0,        32'h0);
    drive("r0load",  1, 5'd0, 32'h0,        5'd0, 32'h0,       1, 1, 5'd0, 32'hFFFFFFFF, 32'h0,         0, 32'h0,        32'h0);
    drive("r0hist",  1, 5'd0, 32'h0,        5'd0, 32'h0,       0, 0, 5'd0, 32'h0,        32'h12345,     0, 32'h0,        32'h0);
    // Hold: fill M with r4=0x44, then freeze while EX inputs change.
    drive("hfill",   1, 5'd0, 32'h0,        5'd0, 32'h0,       1, 0, 5'd4, 32'h44,       32'h0,         0, 32'h0,        32'h0);
    drive("hold1",   0, 5'd4, 32'h0,        5'd4, 32'h0,       1, 0, 5'd4, 32'hBAD,      32'h0,         0, 32'h0,        32'h0);
    drive("hold2",   0, 5'd4, 32'h0,        5'd4, 32'h0,       1, 1, 5'd4, 32'hBAD1,     32'h0,         1, 32'h0,        32'h0);
    drive("hold3",   0, 5'd4, 32'h0,        5'd4, 32'h0,       1, 0, 5'd4, 32'hBAD2,     32'h0,         0, 32'h0,        32'h0);
    drive("resume",  1, 5'd4, 32'h0,        5'd4, 32'h0,       0, 0, 5'd0, 32'h0,        32'h0,         0, 32'h44,       32'h44);
    drive("resume2", 1, 5'd4, 32'h0,        5'd0, 32'h0,       1, 0, 5'd4, 32'h55,       32'h0,         0, 32'h55,       32'h0);
    drive("prerst",  1, 5'd6, 32'h0,        5'd0, 32'h0,       1, 0, 5'd6, 32'h66,       32'h0,         0, 32'h66,       32'h0);
    drain();
    check32("cnt.hold", {16'd0, bus.stallCount}, {16'd0, CNT_AFTER_LOAD});

    // Asynchronous reset mid-cycle with M holding r6 and outputs non-zero.
    bus.exWrite = 1'b0;
    #1 bus.reset = 1'b0;
    #1;
    check32("mrst.regPort1", bus.regPort1, 32'h0);
    check32("mrst.regPort2", bus.regPort2, 32'h0);
    check32("mrst.stallCount", {16'd0, bus.stallCount}, 32'h0);
    @(negedge bus.clock);
    bus.reset = 1'b1;
    // History cleared, so r6 must come from the register file, not the old M.
    drive("postrst", 1, 5'd6, 32'h61,       5'd5, 32'h11,      0, 0, 5'd0, 32'h0,        32'h0,         0, 32'h61,       32'h11);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_stage_fwd.md
# mips_stage_fwd

Operand-forwarding and load-use hazard unit: the producer side of the EX-stage forward channel. It tracks the destinations and results of instructions in EX, MEM and WB, and selects each decode-stage source operand from the youngest in-flight producer or the register file. Selected operands are registered so they reach the execute stage as its forwarded `regPort1`/`regPort2` on the following cycle. It also raises a stall on load-use hazards and inserts the bubble.

## Interface
- `ctrl`: input, control bundle, clock and reset first.
  - `ctrl.clock`: input, 1 bit, rising-edge clock.
  - `ctrl.reset`: input, 1 bit, asynchronous active-low reset.
- `advance`: input, 1 bit. Pipeline moves this cycle; when 0 every register holds.
- `decRs`, `decRt`: input, 5 bits each. Source register numbers of the instruction in decode.
- `decRsVal`, `decRtVal`: input, 32 bits each. Register-file read data for those sources.
- `exWrite`: input, 1 bit. The instruction in EX writes a register.
- `exLoad`: input, 1 bit. The instruction in EX is a load; its result arrives in MEM.
- `exRd`: input, 5 bits. Destination register of the EX instruction.
- `exResult`: input, 32 bits. ALU result of the EX instruction.
- `memData`: input, 32 bits. Load data for the instruction currently in MEM.
- `regPort1`, `regPort2`: output, 32 bits each. Registered forwarded operands for EX (rs and rt).
- `stall`: output, 1 bit, combinational. Load-use hazard; decode must hold.
- `stallCount`: output, 16 bits. Saturating count of stall cycles (see Configuration).

## Operation
- Internal history, two slots:
  - `M` = {valid, rd, load, value}
  - `W` = {valid, rd, value}
- On a clock edge with `advance`=1, in order:
  - W.valid ← M.valid; W.rd ← M.rd; W.value ← (M.load ? `memData` : M.value).
  - M.valid ← `exWrite`; M.rd ← `exRd`; M.load ← `exLoad`; M.value ← `exResult`.
- A slot with rd = 0 never matches; register 0 always reads as the register-file value, which is 0.
- Per-operand selection for source s, highest priority first:
  1. EX match (`exWrite` && !`exLoad` && `exRd`==s): `exResult`.
  2. M match, non-load: M.value.
  3. M match, load: `memData`.
  4. W match: W.value.
  5. Otherwise the register-file value.
- `stall` = `exWrite` && `exLoad` && `exRd`≠0 && (`exRd`==`decRs` || `exRd`==`decRt`).
- Output register update on a clock edge with `advance`=1:
  - `stall`=0: `regPort1` ← selected rs value; `regPort2` ← selected rt value.
  - `stall`=1: both outputs ← 0 (bubble). History still shifts, so the load moves to M and the held instruction resolves through rule 3 next cycle.
- `advance`=0: history, outputs and counter all hold. `stall` still reflects its inputs combinationally.

## Timing
- Forwarded operand latency: exactly 1 cycle from decode selection to `regPort1`/`regPort2`.
- `stall` has zero latency and is a pure function of the current inputs.
- Load-use costs exactly one stall cycle. `stall` deasserts on the next cycle because EX then holds the bubble.
- A back-to-back dependent chain (ALU→ALU→ALU) needs no stall at any distance of 1, 2 or 3.
- Simultaneous matches: the youngest producer wins (EX over M over W), even when older slots hold different values.
- Reset, asynchronous and valid mid-operation:
  - M.valid = W.valid = 0; all slot fields 0.
  - `regPort1` = `regPort2` = 0; `stallCount` = 0.
  - First edge after release behaves as an empty pipeline.

## Configuration
- `MIPS_STAGE_FWD_STATS_EN` defined: `stallCount` increments on every edge where `advance`=1 and `stall`=1, saturating at 16'hFFFF, cleared only by reset.
- `MIPS_STAGE_FWD_STATS_EN` undefined: `stallCount` is tied to 16'h0000, no counter register exists, and forwarding behaviour is identical.

## Test plan
- **Reset:** assert `ctrl.reset`=0 mid-stream with history valid → outputs 0, `stallCount` 0. Release, then present decRs=5 with decRsVal=32'h11 → `regPort1`=32'h11 next cycle.
- **EX forward:** EX writes r3=32'hA5A5_0001 (non-load), decode reads rs=r3 with decRsVal=0 → `regPort1`=32'hA5A5_0001 next cycle, `stall`=0.
- **Priority:** r7 written by three consecutive ALU ops with values 1, 2, 3; decode reads r7 alongside the third → `regPort2`=3.
- **Load-use:** EX is a load to r9; decode reads rt=r9.
  - `stall`=1 for exactly one cycle; `regPort2`=0 (bubble).
  - Next cycle, with `memData`=32'hDEAD_BEEF → `regPort2`=32'hDEAD_BEEF.
  - `stallCount` increments by 1 when stats are enabled.
- **Register 0:** EX writes r0=32'hFFFF_FFFF and decode reads rs=r0 with decRsVal=0 → `regPort1`=0, `stall`=0 even when EX is a load.
- **Hold:** `advance`=0 for 3 cycles while the EX inputs change → outputs and history unchanged. Resuming forwards only the values present at the resume edge.
